// File: rtl/mux4_key_loader.sv
// Serial key loader for the MUX4-locked c432 netlist: shifts in a key plus
// slice-XOR checksum, applies the key only on a clean match, locks out after repeated failures.
module mux4_key_loader #(
    parameter int KEY_W    = 12,
    parameter int CHK_W    = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_sdi,
    input  logic             key_sdv,
    input  logic             key_clear,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy,
    output logic             locked,
    output logic [1:0]       fail_cnt
);
    // state    | meaning
    // IDLE     | waiting for key_start; key_clear honoured here only
    // SHIFT    | accepting key then checksum bits, one per key_sdv cycle
    // CHECK    | full frame held; next edge applies key or counts a failure
    // LOCKOUT  | too many failures; all inputs ignored until rst_n

    localparam int              FR_W     = KEY_W + CHK_W;
    localparam int              CNT_W    = $clog2(FR_W + 1);
    localparam int              N_SL     = KEY_W / CHK_W;
    localparam logic [1:0]      FAIL_MAX = 2'(MAX_FAIL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FR_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [FR_W-1:0]  shreg;
    logic [CHK_W-1:0] chk_exp;
    logic             chk_ok;
    logic             last_bit;
    logic [1:0]       fail_inc;

    // New bits enter at the MSB, so after a full frame the first bit sits at shreg[0].
    always_comb begin
        chk_exp = '0;
        for (int i = 0; i < N_SL; i++) begin
            chk_exp = chk_exp ^ shreg[i*CHK_W +: CHK_W];
        end
        chk_ok   = (chk_exp == shreg[FR_W-1 -: CHK_W]);
        last_bit = key_sdv && (bit_cnt == CNT_LAST);
        fail_inc = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (key_start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (key_start)     state_nxt = ST_SHIFT;
                else if (last_bit) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (key_start)                state_nxt = ST_SHIFT;
                else if (chk_ok)              state_nxt = ST_IDLE;
                else if (fail_inc == FAIL_MAX) state_nxt = ST_LOCKOUT;
                else                          state_nxt = ST_IDLE;
            end
            ST_LOCKOUT: state_nxt = ST_LOCKOUT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_SHIFT) || (state == ST_CHECK);
        locked = (state == ST_LOCKOUT);
    end

    // Frame capture and applied-key registers; key only moves on CHECK exit, clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            key_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_clear) begin
                        key       <= '0;
                        key_valid <= 1'b0;
                    end
                    if (key_start) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (key_start) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else if (key_sdv) begin
                        shreg   <= {key_sdi, shreg[FR_W-1:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (key_start) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else if (chk_ok) begin
                        key       <= shreg[KEY_W-1:0];
                        key_valid <= 1'b1;
                        fail_cnt  <= '0;
                    end else begin
                        key       <= '0;
                        key_valid <= 1'b0;
                        key_err   <= 1'b1;
                        fail_cnt  <= fail_inc;
                    end
                end
                ST_LOCKOUT: begin
                    key       <= '0;
                    key_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_key_loader.sv
// Randomised self-checking bench for mux4_key_loader against a frame-level
// model of key application, failure counting and lockout.
module tb_mux4_key_loader;
    logic        clk = 1'b0;
    logic        rst_n, key_start, key_sdi, key_sdv, key_clear;
    logic [11:0] key;
    logic        key_valid, key_err, busy, locked;
    logic [1:0]  fail_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_key;
    logic        m_valid;
    logic [1:0]  m_fail;
    logic        m_locked;

    int          gap_busy_low;
    logic        capt_busy, capt_valid, post_err;
    logic [17:0] res_vec;

    always #5 clk = ~clk;

    mux4_key_loader #(.KEY_W(12), .CHK_W(4), .MAX_FAIL(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_sdi(key_sdi),
        .key_sdv(key_sdv), .key_clear(key_clear), .key(key), .key_valid(key_valid),
        .key_err(key_err), .busy(busy), .locked(locked), .fail_cnt(fail_cnt)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    function automatic logic [3:0] chk_of(input logic [11:0] k);
        return k[3:0] ^ k[7:4] ^ k[11:8];
    endfunction

    function automatic logic [17:0] obs();
        return {key, key_valid, key_err, busy, locked, fail_cnt};
    endfunction

    function automatic logic [17:0] exp_vec(input logic err, input logic bsy);
        return {m_key, m_valid, err, bsy, m_locked, m_fail};
    endfunction

    task automatic model_reset();
        m_key = '0; m_valid = 1'b0; m_fail = '0; m_locked = 1'b0;
    endtask

    task automatic model_frame(input logic [11:0] k, input logic [3:0] c, output logic err);
        err = 1'b0;
        if (!m_locked) begin
            if (c == chk_of(k)) begin
                m_key = k; m_valid = 1'b1; m_fail = '0;
            end else begin
                m_key = '0; m_valid = 1'b0; err = 1'b1;
                if (m_fail < 2'd3) m_fail = m_fail + 2'd1;
                if (m_fail == 2'd3) m_locked = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] fr, input int n, input int ga, input int gb,
                              input int gl, input int clr_at);
        gap_busy_low = 0;
        for (int i = 0; i < n; i++) begin
            key_sdi   = fr[i];
            key_sdv   = 1'b1;
            key_clear = (i == clr_at);
            tick();
            key_sdv   = 1'b0;
            key_clear = 1'b0;
            if ((i == ga || i == gb) && i != n - 1) begin
                for (int g = 0; g < gl; g++) begin
                    tick();
                    if (busy !== 1'b1) gap_busy_low++;
                end
            end
        end
    endtask

    task automatic finish_frame();
        capt_busy  = busy;
        capt_valid = key_valid;
        tick();
        res_vec = obs();
        tick();
        post_err = key_err;
    endtask

    task automatic run_frame(input logic [11:0] k, input logic [3:0] c, input int ga,
                             input int gb, input int gl, input int clr_at);
        start_pulse();
        shift_bits({c, k}, 16, ga, gb, gl, clr_at);
        finish_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_start = 0; key_sdi = 0; key_sdv = 0; key_clear = 0;
        model_reset();
        repeat (2) tick();
        checks++;
        if (obs() !== 18'h0) begin
            errors++; $display("FAIL reset_held got %h exp %h", obs(), 18'h0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs() !== 18'h0) begin
            errors++; $display("FAIL reset_release got %h exp %h", obs(), 18'h0);
        end
    endtask

    task automatic test_good_load();
        logic pre, e;
        pre = m_valid;
        run_frame(12'hA5C, 4'h3, -1, -1, 0, -1);
        model_frame(12'hA5C, 4'h3, e);
        checks++;
        if (capt_busy !== 1'b1) begin
            errors++; $display("FAIL good_busy_in_check got %b exp 1", capt_busy);
        end
        checks++;
        if (capt_valid !== pre) begin
            errors++; $display("FAIL good_valid_early got %b exp %b", capt_valid, pre);
        end
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL good_result got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
        checks++;
        if (post_err !== 1'b0) begin
            errors++; $display("FAIL good_err_after got %b exp 0", post_err);
        end
    endtask

    task automatic test_gapped();
        logic e;
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        m_key = '0; m_valid = 1'b0;
        checks++;
        if (obs() !== exp_vec(1'b0, 1'b0)) begin
            errors++; $display("FAIL clear_idle got %h exp %h", obs(), exp_vec(1'b0, 1'b0));
        end
        run_frame(12'hA5C, 4'h3, 2, 10, 5, -1);
        model_frame(12'hA5C, 4'h3, e);
        checks++;
        if (gap_busy_low !== 0) begin
            errors++; $display("FAIL gap_busy got %0d low cycles exp 0", gap_busy_low);
        end
        checks++;
        if (capt_valid !== 1'b0) begin
            errors++; $display("FAIL gap_valid_early got %b exp 0", capt_valid);
        end
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL gap_result got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
    endtask

    task automatic test_bad_chk();
        logic e;
        run_frame(12'hA5C, 4'h4, -1, -1, 0, -1);
        model_frame(12'hA5C, 4'h4, e);
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL bad_result got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
        checks++;
        if (post_err !== 1'b0) begin
            errors++; $display("FAIL bad_err_width got %b exp 0", post_err);
        end
    endtask

    task automatic test_restart();
        logic e;
        start_pulse();
        shift_bits(16'($urandom), 7, -1, -1, 0, -1);
        run_frame(12'h123, 4'h0, -1, -1, 0, -1);
        model_frame(12'h123, 4'h0, e);
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL restart_shift got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
        // restart while CHECK holds a bad frame: that frame must never be judged
        start_pulse();
        shift_bits({4'hF, 12'h123}, 16, -1, -1, 0, -1);
        start_pulse();
        checks++;
        if (obs() !== exp_vec(1'b0, 1'b1)) begin
            errors++; $display("FAIL restart_in_check got %h exp %h", obs(), exp_vec(1'b0, 1'b1));
        end
        shift_bits({4'h6, 12'h456}, 16, -1, -1, 0, -1);
        finish_frame();
        model_frame(12'h456, 4'h6, e);
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL restart_check_result got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
    endtask

    task automatic test_clear_start();
        logic [11:0] k;
        logic        e;
        k = 12'($urandom);
        key_clear = 1'b1;
        key_start = 1'b1;
        tick();
        key_clear = 1'b0;
        key_start = 1'b0;
        m_key = '0; m_valid = 1'b0;
        checks++;
        if (obs() !== exp_vec(1'b0, 1'b1)) begin
            errors++; $display("FAIL clear_start got %h exp %h", obs(), exp_vec(1'b0, 1'b1));
        end
        shift_bits({chk_of(k), k}, 16, -1, -1, 0, -1);
        finish_frame();
        model_frame(k, chk_of(k), e);
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL clear_start_load got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [11:0] k;
        logic [3:0]  c;
        logic        pre, e, good;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                key_clear = 1'b1;
                tick();
                key_clear = 1'b0;
                m_key = '0; m_valid = 1'b0;
                checks++;
                if (obs() !== exp_vec(1'b0, 1'b0)) begin
                    errors++; $display("FAIL rnd_clear n=%0d got %h exp %h", n, obs(), exp_vec(1'b0, 1'b0));
                end
            end
            k    = 12'($urandom);
            good = ($urandom_range(0, 9) < 7) || (m_fail == 2'd2);
            c    = good ? chk_of(k) : chk_of(k) ^ 4'($urandom_range(1, 15));
            pre  = m_valid;
            run_frame(k, c, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1);
            model_frame(k, c, e);
            checks++;
            if ({capt_busy, capt_valid} !== {1'b1, pre}) begin
                errors++; $display("FAIL rnd_capture n=%0d got %b%b exp 1%b", n, capt_busy, capt_valid, pre);
            end
            checks++;
            if (res_vec !== exp_vec(e, 1'b0)) begin
                errors++; $display("FAIL rnd_result n=%0d got %h exp %h", n, res_vec, exp_vec(e, 1'b0));
            end
            checks++;
            if (post_err !== 1'b0 || gap_busy_low !== 0) begin
                errors++; $display("FAIL rnd_err_gap n=%0d got err %b gaps %0d exp 0 0", n, post_err, gap_busy_low);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] k;
        logic        e;
        start_pulse();
        shift_bits(16'($urandom), 9, -1, -1, 0, -1);
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (obs() !== 18'h0) begin
            errors++; $display("FAIL rst_async got %h exp %h", obs(), 18'h0);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            key_sdi = 1'($urandom);
            key_sdv = 1'b1;
            tick();
        end
        key_sdv = 1'b0;
        checks++;
        if (obs() !== 18'h0) begin
            errors++; $display("FAIL rst_quiet got %h exp %h", obs(), 18'h0);
        end
        k = 12'($urandom);
        run_frame(k, chk_of(k), -1, -1, 0, -1);
        model_frame(k, chk_of(k), e);
        checks++;
        if (res_vec !== exp_vec(e, 1'b0)) begin
            errors++; $display("FAIL rst_reload got %h exp %h", res_vec, exp_vec(e, 1'b0));
        end
    endtask

    task automatic test_lockout();
        logic [11:0] k;
        logic        e;
        k = 12'($urandom);
        run_frame(k, chk_of(k), -1, -1, 0, -1);
        model_frame(k, chk_of(k), e);
        for (int n = 0; n < 3; n++) begin
            k = 12'($urandom);
            run_frame(k, ~chk_of(k), -1, -1, 0, -1);
            model_frame(k, ~chk_of(k), e);
            checks++;
            if (res_vec !== exp_vec(e, 1'b0)) begin
                errors++; $display("FAIL lock_bad n=%0d got %h exp %h", n, res_vec, exp_vec(e, 1'b0));
            end
        end
        checks++;
        if ({locked, fail_cnt} !== 3'b111) begin
            errors++; $display("FAIL lock_state got %b exp 111", {locked, fail_cnt});
        end
        run_frame(12'hA5C, 4'h3, -1, -1, 0, -1);
        model_frame(12'hA5C, 4'h3, e);
        checks++;
        if ({capt_busy, res_vec} !== {1'b0, exp_vec(e, 1'b0)}) begin
            errors++; $display("FAIL lock_ignore_frame got %h exp %h", {capt_busy, res_vec}, {1'b0, exp_vec(e, 1'b0)});
        end
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        checks++;
        if (obs() !== exp_vec(1'b0, 1'b0)) begin
            errors++; $display("FAIL lock_ignore_clear got %h exp %h", obs(), exp_vec(1'b0, 1'b0));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (obs() !== 18'h0) begin
            errors++; $display("FAIL lock_reset got %h exp %h", obs(), 18'h0);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_gapped();
        test_bad_chk();
        test_restart();
        test_clear_start();
        test_random();
        test_reset_mid_frame();
        test_lockout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
